lupdate: RTL and testbench

- Downstream neighbour of the beacon report stage, on the 134-bit packet bus.
- Inspects every packet and recognises beacon update messages from the CNC addressed to this node.
- For a recognised update: latches the new beacon configuration registers, toggles beacon_update_master, and removes the packet from the stream.
- All other packets pass through with a fixed 3-cycle latency.

---
 rtl/lupdate_pkg.sv | 40 ++++
 rtl/lupdate_dly3.sv | 45 ++++
 rtl/lupdate.sv | 163 ++++++++++++++++
 tb/tb_lupdate.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lupdate_pkg.sv
// Shared packet-bus layout and beacon-update constants for the lupdate stage.
// Matches the field map used by the upstream beacon report stage.
package lupdate_pkg;

    localparam int BUS_W    = 134;
    localparam int HDR_HI   = 133;
    localparam int HDR_LO   = 132;
    localparam int DMAC_HI  = 127;
    localparam int DMAC_LO  = 80;
    localparam int DIR_BIT  = 79;
    localparam int TBP_HI   = 63;
    localparam int TBP_LO   = 32;
    localparam int ETYPE_HI = 31;
    localparam int ETYPE_LO = 16;
    localparam int MTYPE_HI = 11;
    localparam int MTYPE_LO = 8;

    localparam logic [1:0]  HDR_HEAD  = 2'b01;
    localparam logic [1:0]  HDR_MID   = 2'b11;
    localparam logic [1:0]  HDR_TAIL  = 2'b10;
    localparam logic [15:0] PTP_ETYPE = 16'h88f7;
    localparam logic [3:0]  WIDX_HDR  = 4'd2;
    localparam logic [3:0]  WIDX_BCN  = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_UPD
    } lu_state_e;

    typedef struct packed {
        logic [BUS_W-1:0] data;
        logic             wr;
        logic             valid;
        logic             valid_wr;
        logic             tag;
        logic             drop;
    } lu_stage_t;

endpackage

// File: rtl/lupdate_dly3.sv
// Three-stage tagged delay line; stages whose packet tag matches set_tag are
// marked dropped as they shift, and dropped words leave with strobes/data zeroed.
module lupdate_dly3 import lupdate_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  lu_stage_t        in_stage,
    input  logic             set_drop,
    input  logic             set_tag,
    output logic [BUS_W-1:0] out_data,
    output logic             out_wr,
    output logic             out_valid,
    output logic             out_valid_wr
);

    lu_stage_t s0;
    lu_stage_t s1;
    logic      s1_drop_nx;
    logic      s2_drop_nx;

    always_comb begin
        s1_drop_nx = s0.drop | (set_drop && (s0.tag == set_tag));
        s2_drop_nx = s1.drop | (set_drop && (s1.tag == set_tag));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0           <= '0;
            s1           <= '0;
            out_data     <= '0;
            out_wr       <= 1'b0;
            out_valid    <= 1'b0;
            out_valid_wr <= 1'b0;
        end else begin
            s0           <= in_stage;
            s1           <= s0;
            s1.drop      <= s1_drop_nx;
            // s2 is the output register; a dropped word is blanked on entry
            out_data     <= s2_drop_nx ? '0 : s1.data;
            out_wr       <= s1.wr & ~s2_drop_nx;
            out_valid    <= s1.valid;
            out_valid_wr <= s1.valid_wr & ~s2_drop_nx;
        end
    end

endmodule

// File: rtl/lupdate.sv
// Beacon update consumer: applies CNC beacon updates addressed to this node and
// strips them from the stream. Define LUPDATE_MIRROR_EN to forward them instead.
module lupdate import lupdate_pkg::*; #(
    parameter logic [31:0] DEF_TB_PARA   = 32'h0,
    parameter logic        DEF_DIRECTION = 1'b0,
    parameter logic [3:0]  UPD_MSG_TYPE  = 4'hd
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_lu_data_wr,
    input  logic [BUS_W-1:0] in_lu_data,
    input  logic             in_lu_data_valid,
    input  logic             in_lu_data_valid_wr,
    input  logic [47:0]      in_local_mac_id,
    output logic             out_lu_data_wr,
    output logic [BUS_W-1:0] out_lu_data,
    output logic             out_lu_data_valid,
    output logic             out_lu_data_valid_wr,
    output logic             beacon_update_master,
    output logic             direction,
    output logic [31:0]      token_bucket_para,
    output logic [47:0]      direct_mac_addr,
    output logic [15:0]      upd_err_cnt
);

    lu_state_e   state, state_nx;
    logic [3:0]  widx, cur_idx;
    logic        tag, cur_tag;
    logic        is_head, is_tail, is_match;
    logic        drop_word, set_drop, capture, commit, err_inc;
    logic        drop_eff, set_drop_eff;
    logic [47:0] sh_mac, cm_mac;
    logic        sh_dir, cm_dir;
    logic [31:0] sh_tbp, cm_tbp;
    lu_stage_t   in_stage;

    always_comb begin
        is_head  = in_lu_data_wr && (in_lu_data[HDR_HI:HDR_LO] == HDR_HEAD);
        is_tail  = in_lu_data_wr && (in_lu_data[HDR_HI:HDR_LO] == HDR_TAIL);
        cur_idx  = is_head ? 4'd0 : widx;
        cur_tag  = is_head ? ~tag : tag;
        is_match = (in_lu_data[DMAC_HI:DMAC_LO] == in_local_mac_id) &&
                   (in_lu_data[ETYPE_HI:ETYPE_LO] == PTP_ETYPE) &&
                   (in_lu_data[MTYPE_HI:MTYPE_LO] == UPD_MSG_TYPE);
        // a tail landing on the beacon word commits the fields it carries
        cm_mac   = capture ? in_lu_data[DMAC_HI:DMAC_LO] : sh_mac;
        cm_dir   = capture ? in_lu_data[DIR_BIT]         : sh_dir;
        cm_tbp   = capture ? in_lu_data[TBP_HI:TBP_LO]   : sh_tbp;
    end

    always_comb begin
        state_nx  = state;
        drop_word = 1'b0;
        set_drop  = 1'b0;
        capture   = 1'b0;
        commit    = 1'b0;
        err_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_head) state_nx = ST_FWD;
            end
            ST_FWD: begin
                if (is_head) begin
                    state_nx = ST_FWD;
                end else if (in_lu_data_wr && cur_idx == WIDX_HDR && is_match) begin
                    drop_word = 1'b1;
                    set_drop  = 1'b1;
                    if (is_tail) begin
                        err_inc  = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_UPD;
                    end
                end else if (is_tail) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_UPD: begin
                if (is_head) begin
                    err_inc  = 1'b1;
                    state_nx = ST_FWD;
                end else begin
                    drop_word = 1'b1;
                    capture   = in_lu_data_wr && (cur_idx == WIDX_BCN);
                    if (is_tail) begin
                        state_nx = ST_IDLE;
                        if (cur_idx >= WIDX_BCN && in_lu_data_valid) commit  = 1'b1;
                        else                                          err_inc = 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

`ifdef LUPDATE_MIRROR_EN
    assign drop_eff     = 1'b0;
    assign set_drop_eff = 1'b0;
`else
    assign drop_eff     = drop_word;
    assign set_drop_eff = set_drop;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            widx  <= 4'd0;
            tag   <= 1'b0;
        end else begin
            state <= state_nx;
            if (in_lu_data_wr) widx <= (cur_idx == 4'hf) ? cur_idx : cur_idx + 4'd1;
            if (is_head) tag <= cur_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_mac               <= '0;
            sh_dir               <= 1'b0;
            sh_tbp               <= '0;
            direct_mac_addr      <= '0;
            direction            <= DEF_DIRECTION;
            token_bucket_para    <= DEF_TB_PARA;
            beacon_update_master <= 1'b0;
            upd_err_cnt          <= '0;
        end else begin
            if (capture) begin
                sh_mac <= in_lu_data[DMAC_HI:DMAC_LO];
                sh_dir <= in_lu_data[DIR_BIT];
                sh_tbp <= in_lu_data[TBP_HI:TBP_LO];
            end
            if (commit) begin
                direct_mac_addr      <= cm_mac;
                direction            <= cm_dir;
                token_bucket_para    <= cm_tbp;
                beacon_update_master <= ~beacon_update_master;
            end
            if (err_inc && upd_err_cnt != 16'hffff) upd_err_cnt <= upd_err_cnt + 16'd1;
        end
    end

    always_comb begin
        in_stage.data     = in_lu_data;
        in_stage.wr       = in_lu_data_wr;
        in_stage.valid    = in_lu_data_valid;
        in_stage.valid_wr = in_lu_data_valid_wr;
        in_stage.tag      = cur_tag;
        in_stage.drop     = drop_eff;
    end

    lupdate_dly3 u_dly3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_stage     (in_stage),
        .set_drop     (set_drop_eff),
        .set_tag      (cur_tag),
        .out_data     (out_lu_data),
        .out_wr       (out_lu_data_wr),
        .out_valid    (out_lu_data_valid),
        .out_valid_wr (out_lu_data_valid_wr)
    );

endmodule

// File: tb/tb_lupdate.sv
// Scoreboard bench for lupdate: packet-level reference model, random and directed packets.
module tb_lupdate;

    localparam logic [31:0] DEF_TBP = 32'h1234_5678;
    localparam logic        DEF_DIR = 1'b1;
    localparam logic [47:0] LOCAL   = 48'h02_11_22_33_44_55;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_lu_data_wr = 1'b0;
    logic [133:0] in_lu_data = '0;
    logic         in_lu_data_valid = 1'b0;
    logic         in_lu_data_valid_wr = 1'b0;
    logic [47:0]  in_local_mac_id = LOCAL;
    logic         out_lu_data_wr;
    logic [133:0] out_lu_data;
    logic         out_lu_data_valid;
    logic         out_lu_data_valid_wr;
    logic         beacon_update_master;
    logic         direction;
    logic [31:0]  token_bucket_para;
    logic [47:0]  direct_mac_addr;
    logic [15:0]  upd_err_cnt;

    lupdate #(.DEF_TB_PARA(DEF_TBP), .DEF_DIRECTION(DEF_DIR), .UPD_MSG_TYPE(4'hd)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_lu_data_wr        (in_lu_data_wr),
        .in_lu_data           (in_lu_data),
        .in_lu_data_valid     (in_lu_data_valid),
        .in_lu_data_valid_wr  (in_lu_data_valid_wr),
        .in_local_mac_id      (in_local_mac_id),
        .out_lu_data_wr       (out_lu_data_wr),
        .out_lu_data          (out_lu_data),
        .out_lu_data_valid    (out_lu_data_valid),
        .out_lu_data_valid_wr (out_lu_data_valid_wr),
        .beacon_update_master (beacon_update_master),
        .direction            (direction),
        .token_bucket_para    (token_bucket_para),
        .direct_mac_addr      (direct_mac_addr),
        .upd_err_cnt          (upd_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [133:0] data;
        logic         vwr;
        logic         vld;
        int           due;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [127:0] pkt[16];
    bit           pending_chk = 0;

    // reference model state
    logic [47:0]  m_mac = '0;
    logic         m_dir = DEF_DIR;
    logic [31:0]  m_tbp = DEF_TBP;
    logic         m_bum = 1'b0;
    logic [15:0]  m_err = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every presented word must be the next expected one, exactly on time
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_word actual none required %h at cycle %0d", mon_e.data, mon_e.due);
            end
            if (out_lu_data_wr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stray_word actual %h required none", out_lu_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_lu_data !== mon_e.data || out_lu_data_valid_wr !== mon_e.vwr ||
                        (mon_e.vwr && out_lu_data_valid !== mon_e.vld) || cyc != mon_e.due) begin
                        errors++;
                        $display("FAIL out_word actual %h vwr=%b vld=%b cyc=%0d required %h vwr=%b vld=%b cyc=%0d",
                                 out_lu_data, out_lu_data_valid_wr, out_lu_data_valid, cyc,
                                 mon_e.data, mon_e.vwr, mon_e.vld, mon_e.due);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, req);
        end
    endtask

    task automatic chk_regs(input string tagname);
        chk({tagname, "_mac"}, 64'(direct_mac_addr), 64'(m_mac));
        chk({tagname, "_dir"}, 64'(direction), 64'(m_dir));
        chk({tagname, "_tbp"}, 64'(token_bucket_para), 64'(m_tbp));
        chk({tagname, "_bum"}, 64'(beacon_update_master), 64'(m_bum));
        chk({tagname, "_err"}, 64'(upd_err_cnt), 64'(m_err));
    endtask

    task automatic next_negedge();
        @(negedge clk);
        if (pending_chk) chk_regs("regs");
        pending_chk = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_negedge();
            in_lu_data_wr       = 1'b0;
            in_lu_data_valid_wr = 1'b0;
            in_lu_data_valid    = 1'b0;
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic fill_random(input int len);
        for (int i = 0; i < 16; i++) pkt[i] = (i < len) ? rnd128() : '0;
    endtask

    task automatic make_update_hdr(input logic [47:0] dmac);
        pkt[2][127:80] = dmac;
        pkt[2][31:16]  = 16'h88f7;
        pkt[2][11:8]   = 4'hd;
    endtask

    // Drives one packet; the model decides at packet level whether it is consumed.
    task automatic send_pkt(input int len, input bit tail, input bit tvld);
        bit           is_upd;
        bit           last;
        logic [1:0]   hdr;
        logic [133:0] w;
        is_upd = (len >= 3) && (pkt[2][127:80] == LOCAL) &&
                 (pkt[2][31:16] == 16'h88f7) && (pkt[2][11:8] == 4'hd);
        for (int i = 0; i < len; i++) begin
            next_negedge();
            last = tail && (i == len - 1);
            hdr  = (i == 0) ? 2'b01 : (last ? 2'b10 : 2'b11);
            w    = {hdr, 4'h0, pkt[i]};
            in_lu_data          = w;
            in_lu_data_wr       = 1'b1;
            in_lu_data_valid_wr = last;
            in_lu_data_valid    = last & tvld;
            if (!is_upd) exp_q.push_back('{data: w, vwr: last, vld: last & tvld, due: cyc + 3});
        end
        if (is_upd) begin
            if (tail && len >= 7 && tvld) begin
                m_mac = pkt[6][127:80];
                m_dir = pkt[6][79];
                m_tbp = pkt[6][63:32];
                m_bum = ~m_bum;
            end else if (m_err != 16'hffff) begin
                m_err = m_err + 16'd1;
            end
        end
        pending_chk = tail;
    endtask

    initial begin
        int len, kind, gap;
        bit tail, tvld;

        // reset state
        repeat (3) @(negedge clk);
        chk_regs("reset");
        chk("reset_out_wr", 64'(out_lu_data_wr), 64'd0);
        chk("reset_out_vwr", 64'(out_lu_data_valid_wr), 64'd0);
        chk("reset_out_data", 64'(out_lu_data[63:0]), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // non-PTP 8-word packet passes through
        fill_random(8);
        pkt[2][127:80] = LOCAL;
        pkt[2][31:16]  = 16'h0800;
        send_pkt(8, 1, 1);
        idle(4);

        // update to this node with a full beacon word
        fill_random(13);
        make_update_hdr(LOCAL);
        pkt[6] = {48'h0a0b0c0d0e0f, 1'b1, 15'b0, 32'h00100020, 32'b0};
        send_pkt(13, 1, 1);
        idle(4);
        chk("upd_mac_abs", 64'(direct_mac_addr), 64'h0a0b0c0d0e0f);
        chk("upd_dir_abs", 64'(direction), 64'd1);
        chk("upd_tbp_abs", 64'(token_bucket_para), 64'h00100020);
        chk("upd_bum_abs", 64'(beacon_update_master), 64'd1);

        // same update addressed elsewhere is forwarded
        pkt[2][127:80] = 48'h02_11_22_33_44_56;
        pkt[6] = {48'h0b0b0b0b0b0b, 1'b0, 15'b0, 32'h00aa00bb, 32'b0};
        send_pkt(13, 1, 1);
        idle(4);

        // truncated update: consumed, error counted
        fill_random(5);
        make_update_hdr(LOCAL);
        send_pkt(5, 1, 1);
        idle(4);
        chk("trunc_err_abs", 64'(upd_err_cnt), 64'd1);

        // update whose tail reports invalid
        fill_random(13);
        make_update_hdr(LOCAL);
        send_pkt(13, 1, 0);
        idle(4);
        chk("inval_err_abs", 64'(upd_err_cnt), 64'd2);
        chk("inval_bum_abs", 64'(beacon_update_master), 64'd1);

        // random mix: plain, update, near-miss; occasional missing tail
        for (int p = 0; p < 40; p++) begin
            len  = 2 + int'($urandom_range(0, 12));
            kind = int'($urandom_range(0, 3));
            tail = ($urandom_range(0, 7) != 0) || (p == 39);
            tvld = ($urandom_range(0, 3) != 0);
            gap  = int'($urandom_range(0, 2));
            fill_random(len);
            if (kind == 1 || kind == 3) begin
                make_update_hdr(LOCAL);
            end else if (kind == 2) begin
                make_update_hdr(LOCAL);
                case ($urandom_range(0, 2))
                    0:       pkt[2][80] = ~pkt[2][80];
                    1:       pkt[2][31:16] = 16'h0800;
                    default: pkt[2][11:8] = 4'hc;
                endcase
            end
            send_pkt(len, tail, tvld);
            idle(gap);
        end
        idle(5);

        // forward packet, update right behind it, reset in the middle of the update
        fill_random(8);
        pkt[2][31:16] = 16'h0800;
        send_pkt(8, 1, 1);
        fill_random(9);
        make_update_hdr(LOCAL);
        send_pkt(9, 0, 0);
        @(negedge clk);
        rst_n         = 1'b0;
        in_lu_data_wr = 1'b0;
        m_mac = '0;
        m_dir = DEF_DIR;
        m_tbp = DEF_TBP;
        m_bum = 1'b0;
        m_err = '0;
        #1;
        chk_regs("midrst");
        chk("midrst_out_wr", 64'(out_lu_data_wr), 64'd0);
        chk("midrst_out_vwr", 64'(out_lu_data_valid_wr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        chk_regs("after_rst");
        chk("drain_queue", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
